// File: rtl/core_debug_regs_pkg.sv
// Shared constants and types for the core debug/run-control register block.
// Holds the register map, the clock-mode encoding and the per-port write request type.
package core_debug_regs_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_CYCLEL   = 6'h00;
   localparam logic [ADDR_W-1:0] ADDR_CYCLEH   = 6'h01;
   localparam logic [ADDR_W-1:0] ADDR_CLK_MODE = 6'h02;
   localparam logic [ADDR_W-1:0] ADDR_STEPS    = 6'h03;
   localparam logic [ADDR_W-1:0] ADDR_STALLS   = 6'h04;
   localparam logic [ADDR_W-1:0] ADDR_CTRL     = 6'h05;
   localparam logic [ADDR_W-1:0] ADDR_ID       = 6'h06;

   localparam int CTRL_CLEAR_BIT = 0;

   typedef enum logic {
      CLK_FREE = 1'b0,
      CLK_STEP = 1'b1
   } clk_mode_t;

   typedef struct packed {
      logic              mode_we;
      logic              steps_we;
      logic              ctrl_we;
      logic [DATA_W-1:0] data;
   } port_wr_t;

endpackage

// File: rtl/core_debug_regs_if.sv
// Single-cycle register bus (no waitrequest) used by the CPU and JTAG ports.
interface core_debug_regs_if;
   import core_debug_regs_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic [DATA_W-1:0] readdata;
   logic              write;
   logic [DATA_W-1:0] writedata;

   modport master (output address, read, write, writedata, input readdata);
   modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/core_debug_regs_port.sv
// One register-bus port: address decode, registered read mux and the
// private high-word shadow that makes a CYCLEL/CYCLEH pair read atomically.
module core_debug_regs_port
   import core_debug_regs_pkg::*;
#(
   parameter logic [31:0] ID_VALUE = 32'hCE43_0201
) (
   input  logic                clk,
   input  logic                reset,
   core_debug_regs_if.slave    bus,
   input  logic [63:0]         cycle,
   input  clk_mode_t           clk_mode,
   input  logic [DATA_W-1:0]   steps,
   input  logic [DATA_W-1:0]   stalls,
   output port_wr_t            wr
);

   logic [DATA_W-1:0] shadow;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] readdata_q;

   always_comb begin
      rd_val = '0;
      case (bus.address)
         ADDR_CYCLEL:   rd_val = cycle[31:0];
         ADDR_CYCLEH:   rd_val = shadow;
         ADDR_CLK_MODE: rd_val = {31'd0, clk_mode};
         ADDR_STEPS:    rd_val = steps;
         ADDR_STALLS:   rd_val = stalls;
         ADDR_ID:       rd_val = ID_VALUE;
         default:       rd_val = '0;
      endcase
   end

   // CYCLEH returns the shadow as it was before this read; the shadow only
   // moves on a CYCLEL read, so the pair is coherent even across a carry.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_q <= '0;
         shadow     <= '0;
      end else begin
         readdata_q <= bus.read ? rd_val : '0;
         if (bus.read && bus.address == ADDR_CYCLEL)
            shadow <= cycle[63:32];
      end
   end

   assign bus.readdata = readdata_q;

   always_comb begin
      wr          = '0;
      wr.mode_we  = bus.write && (bus.address == ADDR_CLK_MODE);
      wr.steps_we = bus.write && (bus.address == ADDR_STEPS);
      wr.ctrl_we  = bus.write && (bus.address == ADDR_CTRL);
      wr.data     = bus.writedata;
   end

endmodule

// File: rtl/core_debug_regs.sv
// Debug/run-control registers for the core: cycle and stall counters, clock mode,
// step counter and core_run_en. DEBUG_REGS_STALL_CNT_EN builds the stall counter.
module core_debug_regs
   import core_debug_regs_pkg::*;
#(
   parameter logic [31:0] ID_VALUE = 32'hCE43_0201
) (
   input  logic             clk,
   input  logic             reset,
   core_debug_regs_if.slave s1,
   core_debug_regs_if.slave s2,
   input  logic             core_stall,
   output logic             core_run_en
);

   logic [63:0]       cycle_cnt;
   logic [DATA_W-1:0] steps;
   logic [DATA_W-1:0] stalls;
   clk_mode_t         clk_mode;
   port_wr_t          wr1;
   port_wr_t          wr2;
   logic              mode_we;
   logic              mode_data;
   logic              steps_we;
   logic [DATA_W-1:0] steps_data;
   logic              clear;

   core_debug_regs_port #(.ID_VALUE(ID_VALUE)) u_port1 (
      .clk      (clk),
      .reset    (reset),
      .bus      (s1),
      .cycle    (cycle_cnt),
      .clk_mode (clk_mode),
      .steps    (steps),
      .stalls   (stalls),
      .wr       (wr1)
   );

   core_debug_regs_port #(.ID_VALUE(ID_VALUE)) u_port2 (
      .clk      (clk),
      .reset    (reset),
      .bus      (s2),
      .cycle    (cycle_cnt),
      .clk_mode (clk_mode),
      .steps    (steps),
      .stalls   (stalls),
      .wr       (wr2)
   );

   // JTAG (port 2) wins any same-register collision with the CPU.
   always_comb begin
      mode_we    = wr1.mode_we | wr2.mode_we;
      mode_data  = wr2.mode_we ? wr2.data[0] : wr1.data[0];
      steps_we   = wr1.steps_we | wr2.steps_we;
      steps_data = wr2.steps_we ? wr2.data : wr1.data;
      clear      = wr2.ctrl_we ? wr2.data[CTRL_CLEAR_BIT]
                 : (wr1.ctrl_we & wr1.data[CTRL_CLEAR_BIT]);
   end

   // Reset forces free-run so the pipeline is never held while coming up.
   assign core_run_en = reset | (clk_mode == CLK_FREE) | (steps != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
         steps     <= '0;
         clk_mode  <= CLK_FREE;
      end else begin
         if (clear)
            cycle_cnt <= '0;
         else if (core_run_en)
            cycle_cnt <= cycle_cnt + 64'd1;

         if (mode_we)
            clk_mode <= clk_mode_t'(mode_data);

         if (steps_we)
            steps <= steps_data;
         else if (core_run_en && clk_mode == CLK_STEP && steps != '0)
            steps <= steps - 32'd1;
      end
   end

`ifdef DEBUG_REGS_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stalls <= '0;
      else if (clear)
         stalls <= '0;
      else if (core_run_en && core_stall && stalls != '1)
         stalls <= stalls + 32'd1;
   end
`else
   logic unused_core_stall;
   assign unused_core_stall = core_stall;
   assign stalls            = '0;
`endif

endmodule

// File: tb/tb_core_debug_regs.sv
// Self-checking bench for core_debug_regs: directed scenarios plus randomized
// dual-port traffic compared against a register-level reference model.
`timescale 1ns/1ps
module tb_core_debug_regs;
   import core_debug_regs_pkg::*;

   localparam logic [31:0] ID = 32'hCE43_0201;
`ifdef DEBUG_REGS_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic core_stall;
   logic core_run_en;

   core_debug_regs_if s1_bus ();
   core_debug_regs_if s2_bus ();

   core_debug_regs #(.ID_VALUE(ID)) dut (
      .clk         (clk),
      .reset       (reset),
      .s1          (s1_bus),
      .s2          (s2_bus),
      .core_stall  (core_stall),
      .core_run_en (core_run_en)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [63:0] m_cycle  = '0;
   logic [31:0] m_stalls = '0;
   logic [31:0] m_steps  = '0;
   logic        m_mode   = 1'b0;
   logic [31:0] m_sh1    = '0;
   logic [31:0] m_sh2    = '0;
   logic [31:0] m_rd1    = '0;
   logic [31:0] m_rd2    = '0;

   function automatic logic [31:0] model_read(input logic [5:0] a, input logic [31:0] sh);
      case (a)
         6'd0:    return m_cycle[31:0];
         6'd1:    return sh;
         6'd2:    return {31'd0, m_mode};
         6'd3:    return m_steps;
         6'd4:    return STALL_EN ? m_stalls : 32'd0;
         6'd6:    return ID;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic exp_run();
      return reset | !m_mode | (m_steps != 0);
   endfunction

   task automatic idle_bus();
      s1_bus.read = 0; s1_bus.write = 0; s1_bus.address = '0; s1_bus.writedata = '0;
      s2_bus.read = 0; s2_bus.write = 0; s2_bus.address = '0; s2_bus.writedata = '0;
   endtask

   task automatic rd(input int port, input logic [5:0] a);
      if (port == 1) begin s1_bus.read = 1; s1_bus.address = a; end
      else           begin s2_bus.read = 1; s2_bus.address = a; end
   endtask

   task automatic wr(input int port, input logic [5:0] a, input logic [31:0] d);
      if (port == 1) begin s1_bus.write = 1; s1_bus.address = a; s1_bus.writedata = d; end
      else           begin s2_bus.write = 1; s2_bus.address = a; s2_bus.writedata = d; end
   endtask

   // Advance one clock: model the edge from the currently driven inputs, then
   // sample point is 1ns after the edge.
   task automatic cyc();
      logic [63:0] n_cycle;
      logic [31:0] n_stalls, n_steps, n_sh1, n_sh2, n_rd1, n_rd2;
      logic        n_mode, run, clr;
      if (reset) begin
         n_cycle = '0; n_stalls = '0; n_steps = '0; n_mode = 0;
         n_sh1 = '0; n_sh2 = '0; n_rd1 = '0; n_rd2 = '0;
      end else begin
         run   = !m_mode || (m_steps != 0);
         n_rd1 = s1_bus.read ? model_read(s1_bus.address, m_sh1) : 32'd0;
         n_rd2 = s2_bus.read ? model_read(s2_bus.address, m_sh2) : 32'd0;
         n_sh1 = (s1_bus.read && s1_bus.address == 0) ? m_cycle[63:32] : m_sh1;
         n_sh2 = (s2_bus.read && s2_bus.address == 0) ? m_cycle[63:32] : m_sh2;
         n_mode = m_mode;
         if (s1_bus.write && s1_bus.address == 2) n_mode = s1_bus.writedata[0];
         if (s2_bus.write && s2_bus.address == 2) n_mode = s2_bus.writedata[0];
         n_steps = (run && m_mode && m_steps != 0) ? m_steps - 1 : m_steps;
         if (s1_bus.write && s1_bus.address == 3) n_steps = s1_bus.writedata;
         if (s2_bus.write && s2_bus.address == 3) n_steps = s2_bus.writedata;
         clr = 0;
         if (s1_bus.write && s1_bus.address == 5) clr = s1_bus.writedata[0];
         if (s2_bus.write && s2_bus.address == 5) clr = s2_bus.writedata[0];
         n_cycle  = clr ? 64'd0 : m_cycle + (run ? 64'd1 : 64'd0);
         n_stalls = clr ? 32'd0 :
                    (run && core_stall && m_stalls != 32'hFFFF_FFFF) ? m_stalls + 1 : m_stalls;
      end
      @(posedge clk);
      #1;
      m_cycle = n_cycle; m_stalls = n_stalls; m_steps = n_steps; m_mode = n_mode;
      m_sh1 = n_sh1; m_sh2 = n_sh2; m_rd1 = n_rd1; m_rd2 = n_rd2;
   endtask

   task automatic test_reset();
      reset = 1; core_stall = 0; idle_bus();
      repeat (3) cyc();
      total++; if (core_run_en !== 1'b1) begin bad++; $display("FAIL reset_run_en: got %b want 1", core_run_en); end
      total++; if (s1_bus.readdata !== 32'd0) begin bad++; $display("FAIL reset_rd1: got %h want 0", s1_bus.readdata); end
      total++; if (s2_bus.readdata !== 32'd0) begin bad++; $display("FAIL reset_rd2: got %h want 0", s2_bus.readdata); end
      reset = 0;
   endtask

   task automatic test_idle_reads();
      idle_bus();
      repeat (10) cyc();
      total++; if (core_run_en !== 1'b1) begin bad++; $display("FAIL idle_run_en: got %b want 1", core_run_en); end
      rd(1, ADDR_CYCLEL); cyc(); idle_bus();
      total++; if (s1_bus.readdata !== 32'd10) begin bad++; $display("FAIL idle_cyclel: got %0d want 10", s1_bus.readdata); end
      rd(1, ADDR_CYCLEH); rd(2, ADDR_ID); cyc(); idle_bus();
      total++; if (s1_bus.readdata !== 32'd0) begin bad++; $display("FAIL idle_cycleh: got %h want 0", s1_bus.readdata); end
      total++; if (s2_bus.readdata !== ID) begin bad++; $display("FAIL idle_id: got %h want %h", s2_bus.readdata, ID); end
      cyc();
      total++; if (s1_bus.readdata !== 32'd0) begin bad++; $display("FAIL idle_no_read: got %h want 0", s1_bus.readdata); end
   endtask

   task automatic test_step();
      int n_high;
      logic [31:0] c0;
      idle_bus(); wr(2, ADDR_CLK_MODE, 32'd1); cyc();
      idle_bus(); cyc();
      total++; if (core_run_en !== 1'b0) begin bad++; $display("FAIL step_mode_stop: got %b want 0", core_run_en); end
      c0 = m_cycle[31:0];
      wr(2, ADDR_STEPS, 32'd3); cyc(); idle_bus();
      n_high = 0;
      for (int i = 0; i < 20; i++) begin
         if (core_run_en) n_high++;
         cyc();
      end
      total++; if (n_high != 3) begin bad++; $display("FAIL step_count: got %0d want 3", n_high); end
      rd(2, ADDR_STEPS); rd(1, ADDR_CYCLEL); cyc(); idle_bus();
      total++; if (s2_bus.readdata !== 32'd0) begin bad++; $display("FAIL step_steps_zero: got %0d want 0", s2_bus.readdata); end
      total++; if (s1_bus.readdata !== c0 + 32'd3) begin bad++; $display("FAIL step_cyclel: got %0d want %0d", s1_bus.readdata, c0 + 32'd3); end
   endtask

   task automatic test_steps_conflict();
      idle_bus(); wr(1, ADDR_STEPS, 32'd5); wr(2, ADDR_STEPS, 32'd9); cyc(); idle_bus();
      rd(1, ADDR_STEPS); cyc(); idle_bus();
      total++; if (s1_bus.readdata !== 32'd9) begin bad++; $display("FAIL steps_conflict: got %0d want 9", s1_bus.readdata); end
      // a write landing on a decrementing cycle keeps the written value
      wr(1, ADDR_STEPS, 32'd40); cyc(); idle_bus();
      rd(2, ADDR_STEPS); cyc(); idle_bus();
      total++; if (s2_bus.readdata !== 32'd40) begin bad++; $display("FAIL steps_write_vs_dec: got %0d want 40", s2_bus.readdata); end
      wr(1, ADDR_CLK_MODE, 32'd0); cyc(); idle_bus();
      total++; if (core_run_en !== 1'b1) begin bad++; $display("FAIL free_run_restore: got %b want 1", core_run_en); end
   endtask

   task automatic test_clear();
      idle_bus(); repeat (4) cyc();
      wr(1, ADDR_CTRL, 32'd1); cyc(); idle_bus();
      rd(1, ADDR_CYCLEL); cyc(); idle_bus();
      total++; if (s1_bus.readdata !== 32'd0) begin bad++; $display("FAIL clear_cyclel: got %0d want 0", s1_bus.readdata); end
      wr(1, ADDR_CTRL, 32'd1); wr(2, ADDR_CTRL, 32'd0); cyc(); idle_bus();
      rd(2, ADDR_CYCLEL); cyc(); idle_bus();
      total++; if (s2_bus.readdata !== m_rd2 || m_rd2 == 32'd0) begin bad++; $display("FAIL clear_priority: got %0d want %0d", s2_bus.readdata, m_rd2); end
   endtask

   task automatic test_wrap();
      idle_bus();
      force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      m_cycle = 64'h0000_0000_FFFF_FFFF;
      cyc();
      rd(1, ADDR_CYCLEL); cyc(); idle_bus();
      total++; if (s1_bus.readdata !== 32'd0) begin bad++; $display("FAIL wrap_cyclel: got %h want 0", s1_bus.readdata); end
      force dut.cycle_cnt = 64'h0000_0005_0000_0000;
      #1;
      release dut.cycle_cnt;
      m_cycle = 64'h0000_0005_0000_0000;
      rd(2, ADDR_CYCLEL); cyc(); idle_bus();
      cyc();
      rd(1, ADDR_CYCLEH); rd(2, ADDR_CYCLEH); cyc(); idle_bus();
      total++; if (s1_bus.readdata !== 32'd1) begin bad++; $display("FAIL wrap_shadow1: got %h want 1", s1_bus.readdata); end
      total++; if (s2_bus.readdata !== 32'd5) begin bad++; $display("FAIL wrap_shadow2: got %h want 5", s2_bus.readdata); end
   endtask

   task automatic test_stall();
      idle_bus(); wr(2, ADDR_CTRL, 32'd1); cyc(); idle_bus();
      core_stall = 1; repeat (7) cyc(); core_stall = 0;
      rd(1, ADDR_STALLS); cyc(); idle_bus();
      total++;
      if (s1_bus.readdata !== (STALL_EN ? 32'd7 : 32'd0)) begin
         bad++; $display("FAIL stall_count: got %0d want %0d", s1_bus.readdata, STALL_EN ? 7 : 0);
      end
   endtask

   task automatic test_random();
      logic [5:0] a;
      for (int i = 0; i < 400; i++) begin
         idle_bus();
         core_stall = $urandom_range(0, 1);
         for (int p = 1; p <= 2; p++) begin
            a = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
               0: rd(p, a);
               1: begin
                  if (a == ADDR_STEPS)     wr(p, a, $urandom & 32'hF);
                  else if (a == ADDR_CTRL) wr(p, a, {31'd0, $urandom_range(0, 7) == 0});
                  else                     wr(p, a, $urandom);
               end
               default: ;
            endcase
         end
         cyc();
         total++; if (s1_bus.readdata !== m_rd1) begin bad++; $display("FAIL rand_rd1 #%0d: got %h want %h", i, s1_bus.readdata, m_rd1); end
         total++; if (s2_bus.readdata !== m_rd2) begin bad++; $display("FAIL rand_rd2 #%0d: got %h want %h", i, s2_bus.readdata, m_rd2); end
         total++; if (core_run_en !== exp_run()) begin bad++; $display("FAIL rand_run_en #%0d: got %b want %b", i, core_run_en, exp_run()); end
      end
      idle_bus();
   endtask

   task automatic test_reset_mid();
      idle_bus(); wr(1, ADDR_CLK_MODE, 32'd1); wr(2, ADDR_STEPS, 32'd100); cyc(); idle_bus();
      repeat (2) cyc();
      reset = 1; rd(1, ADDR_CYCLEL); rd(2, ADDR_STEPS); cyc(); idle_bus();
      total++; if (core_run_en !== 1'b1) begin bad++; $display("FAIL rst_mid_run_en: got %b want 1", core_run_en); end
      total++; if (s1_bus.readdata !== 32'd0) begin bad++; $display("FAIL rst_mid_rd1: got %h want 0", s1_bus.readdata); end
      total++; if (s2_bus.readdata !== 32'd0) begin bad++; $display("FAIL rst_mid_rd2: got %h want 0", s2_bus.readdata); end
      wr(1, ADDR_STEPS, 32'd7); cyc(); idle_bus();
      reset = 0;
      rd(2, ADDR_STEPS); rd(1, ADDR_CLK_MODE); cyc(); idle_bus();
      total++; if (s2_bus.readdata !== 32'd0) begin bad++; $display("FAIL rst_mid_steps: got %0d want 0", s2_bus.readdata); end
      total++; if (s1_bus.readdata !== 32'd0) begin bad++; $display("FAIL rst_mid_mode: got %0d want 0", s1_bus.readdata); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1; core_stall = 0; idle_bus();
      test_reset();
      test_idle_reads();
      test_step();
      test_steps_conflict();
      test_clear();
      test_wrap();
      test_stall();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_debug_regs.md
# core_debug_regs

Memory-mapped debug and run-control register block that answers the two CPU-register slave ports of `core_top`: s1 for the CPU itself and s2 for JTAG. It keeps a 64-bit executed-cycle counter, an optional stall-cycle counter, a clock-mode register and a down-counting step register. From these it drives `core_run_en`, the enable that lets the pipeline advance. It sits beside the core on the same clock and replaces the constant-zero readdata tie-offs.

## Interface
- `ID_VALUE`, default 32'hCE43_0201, constant returned at the ID address.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `s1_address`  in  6  word address, port 1 (CPU).
- `s1_read`  in  1  read strobe, port 1.
- `s1_readdata`  out  32  read data, port 1.
- `s1_write`  in  1  write strobe, port 1.
- `s1_writedata`  in  32  write data, port 1.
- `s2_address`, `s2_read`, `s2_readdata`, `s2_write`, `s2_writedata`: same as s1, for port 2 (JTAG).
- `core_stall`  in  1  pipeline stall indication from the hazard unit.
- `core_run_en`  out  1  pipeline advance enable.

## Operation
- Register map (word addresses):
  - 0x00 CYCLEL (read-only): low 32 bits of the cycle counter.
  - 0x01 CYCLEH (read-only): high-word snapshot for the accessing port.
  - 0x02 CLK_MODE (read/write): bit0 selects 0 = free-run, 1 = step. Bits 31:1 read 0.
  - 0x03 STEPS (read/write): 32-bit down counter.
  - 0x04 STALLS (read-only): stall-cycle counter.
  - 0x05 CTRL (write-only, reads 0): writing bit0 = 1 clears CYCLE and STALLS.
  - 0x06 ID (read-only): returns `ID_VALUE`.
  - Any other address reads 0; writes to it are ignored.
- `core_run_en` = (CLK_MODE == 0) | (STEPS != 0). It is combinational from the registers.
- Cycle counter: 64 bits, increments every cycle `core_run_en` = 1, wraps from 2^64−1 to 0.
- STALLS: increments when `core_run_en` & `core_stall`, saturates at 32'hFFFF_FFFF.
- STEPS: decrements by 1 each cycle `core_run_en` = 1 and CLK_MODE = 1. It never goes below 0, and it holds its value in free-run.
- Atomic 64-bit read: each port has its own HI shadow.
  - A read of CYCLEL captures counter[63:32] into that port's shadow.
  - A read of CYCLEH returns the shadow.
  - The two ports' shadows are independent.
- Write-conflict priorities:
  - s1 and s2 write the same register in the same cycle: s2 wins.
  - A STEPS write in the same cycle as a decrement: the written value wins.
  - A CTRL clear in the same cycle as an increment: the counter becomes 0.
- Read and write to the same register in the same cycle: the read returns the pre-write value.
- Writes to read-only registers are ignored.

## Timing
- Read latency is exactly 1 cycle.
  - `sN_readdata` is registered. It carries the addressed value on the cycle after `sN_read` = 1, and is 0 in any cycle not preceded by a read.
- There is no waitrequest; every access completes in one cycle.
- Writes take effect at the clock edge; the new value is visible to a read issued the next cycle.
- `core_run_en` reflects a CLK_MODE or STEPS write one cycle after the write strobe.
- Writing STEPS = N while CLK_MODE = 1 gives exactly N cycles with `core_run_en` = 1, then 0.
- Reset, including mid-operation:
  - Clears the counters, STALLS, STEPS, CLK_MODE and both shadows, and sets readdata to 0.
  - `core_run_en` = 1 during and after reset (free-run).
  - Reads and writes presented while `reset` = 1 are ignored.

## Configuration
- `DEBUG_REGS_STALL_CNT_EN`
  - Defined: the STALLS counter exists as described.
  - Undefined: no stall counter is built, 0x04 reads 0, and `core_stall` is unused.

## Structure
- Package `core_debug_regs_pkg` holds:
  - address constants (`ADDR_CYCLEL` … `ADDR_ID`);
  - the CLK_MODE enum (`CLK_FREE`, `CLK_STEP`);
  - the CTRL clear bit index.
- Sub-module `core_debug_regs_port`, instantiated twice, contains:
  - the per-port address decode;
  - the registered read mux;
  - the HI shadow.
- The top level contains the counters, write arbitration and run-enable logic.

## Test plan
- After reset, no writes, 10 cycles → `core_run_en` = 1. Reading CYCLEL returns 10 ± the access cycle, CYCLEH returns 0, and ID returns 32'hCE43_0201.
- Write CLK_MODE = 1 then STEPS = 3 via s2 → `core_run_en` is high for exactly 3 cycles, then 0. CYCLEL advances by 3 plus the pre-write run cycles, and STEPS reads 0.
- Load the cycle counter near wrap: force 32'hFFFF_FFFF in the low word via 2^32 run cycles, or use a bench backdoor. Read CYCLEL (wraps to 0), then CYCLEH → returns the snapshot 1, not a later value. A port-2 read in between must not disturb port 1's shadow.
- Same cycle: s1 writes STEPS = 5 and s2 writes STEPS = 9 → STEPS = 9.
- Same cycle: a CTRL clear and a counting cycle → CYCLEL reads 0 one cycle later.
- With the macro defined: hold `core_stall` = 1 for 7 run cycles → STALLS = 7. With the macro undefined → 0x04 reads 0.
- Assert `reset` with STEPS = 100 and step mode active → next cycle `core_run_en` = 1, STEPS = 0, and readdata on both ports = 0.
